// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the handshaked MEM stage: FSM states,
// one-hot access-size codes and MEM->WB bus packing widths.
package mem_access_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } mau_state_e;

    localparam logic [3:0] SZ_BYTE  = 4'b0001;
    localparam logic [3:0] SZ_HALF  = 4'b0010;
    localparam logic [3:0] SZ_WORD  = 4'b0100;
    localparam logic [3:0] SZ_DWORD = 4'b1000;

    localparam int unsigned WDEST_W = 5;

    function automatic int unsigned mem2wb_w(input int unsigned data_w,
                                             input int unsigned addr_w,
                                             input int unsigned pc_w);
        return WDEST_W + 1 + data_w + addr_w + pc_w;
    endfunction

    // Natural alignment check on the low address bits for the given size.
    function automatic logic misaligned(input logic [3:0] size, input logic [2:0] lo);
        case (size)
            SZ_HALF:  return lo[0];
            SZ_WORD:  return |lo[1:0];
            SZ_DWORD: return |lo;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: write byte enables, store data shift,
// and load data extraction with zero/sign extension.
module mem_lane_align
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [$clog2(DATA_W/8)-1:0] off_i,
    input  logic [3:0]                  size_i,
    input  logic                        st_i,
    input  logic                        ld_sign_i,
    input  logic [DATA_W-1:0]           st_data_i,
    input  logic [DATA_W-1:0]           rdata_i,
    output logic [DATA_W/8-1:0]         wbe_n_o,
    output logic [DATA_W-1:0]           wdata_o,
    output logic [DATA_W-1:0]           ld_data_o
);

    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned OFF_W = $clog2(NB);

    logic [DATA_W-1:0] shifted;
    logic              sign_bit;
    int unsigned       nbytes;
    int unsigned       ext_w;
    int unsigned       off;

    assign wdata_o = st_data_i << {off_i, 3'b000};
    assign shifted = rdata_i >> {off_i, 3'b000};

    always_comb begin
        nbytes   = NB;
        ext_w    = DATA_W;
        sign_bit = 1'b0;
        case (size_i)
            SZ_BYTE: begin nbytes = 1; ext_w = 8;  sign_bit = shifted[7];  end
            SZ_HALF: begin nbytes = 2; ext_w = 16; sign_bit = shifted[15]; end
            SZ_WORD: begin nbytes = 4; ext_w = 32; sign_bit = shifted[31]; end
            default: ;
        endcase
        off = {{(32 - OFF_W){1'b0}}, off_i};
        for (int unsigned i = 0; i < NB; i++) begin
            wbe_n_o[i] = !(st_i && (i >= off) && (i < off + nbytes));
        end
        for (int unsigned i = 0; i < DATA_W; i++) begin
            ld_data_o[i] = (i < ext_w) ? shifted[i] : (ld_sign_i & sign_bit);
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM pipeline stage between EXE and WB: issues loads/stores over a
// req/addr_ok/data_ok memory port and holds the result until WB accepts.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned PC_W   = 32
) (
    input  logic                                   clk,
    input  logic                                   resetn,
    input  logic                                   ex_valid_i,
    output logic                                   mem_allowin_o,
    input  logic                                   ex_ld_i,
    input  logic                                   ex_st_i,
    input  logic                                   ex_ld_sign_i,
    input  logic [3:0]                             ex_size_i,
    input  logic [DATA_W-1:0]                      ex_result_i,
    input  logic [DATA_W-1:0]                      ex_st_data_i,
    input  logic [WDEST_W-1:0]                     ex_wdest_i,
    input  logic                                   ex_we_i,
    input  logic [PC_W-1:0]                        ex_pc_i,
    output logic                                   dm_req_o,
    output logic                                   dm_wr_o,
    output logic [ADDR_W-1:0]                      dm_addr_o,
    output logic [DATA_W/8-1:0]                    dm_wbe_n_o,
    output logic [DATA_W-1:0]                      dm_wdata_o,
    input  logic                                   dm_addr_ok_i,
    input  logic                                   dm_data_ok_i,
    input  logic [DATA_W-1:0]                      dm_rdata_i,
    input  logic                                   wb_allowin_i,
    output logic                                   mem_to_wb_valid_o,
    output logic [mem2wb_w(DATA_W, ADDR_W, PC_W)-1:0] mem2wb_bus_o,
    output logic [WDEST_W-1:0]                     ctl_mem_dest_o,
    output logic                                   ctl_mem_over_o,
    output logic                                   excp_ale_o
);

    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned OFF_W = $clog2(NB);

    mau_state_e           state_q, state_d, entry_state;
    logic                 ld_q, st_q, sign_q, we_q, ale_q;
    logic [3:0]           size_q;
    logic [DATA_W-1:0]    result_q, st_data_q, rdata_q;
    logic [WDEST_W-1:0]   wdest_q;
    logic [PC_W-1:0]      pc_q;

    logic                 latch, ex_ale, capture, we_eff;
    logic [ADDR_W-1:0]    addr;
    logic [DATA_W-1:0]    ld_data, mem_result;

    assign mem_allowin_o = (state_q == IDLE) | ((state_q == DONE) & wb_allowin_i);
    assign latch         = ex_valid_i & mem_allowin_o;
    assign ex_ale        = (ex_ld_i | ex_st_i) & misaligned(ex_size_i, ex_result_i[2:0]);
    assign entry_state   = (ex_ale || !(ex_ld_i || ex_st_i)) ? DONE : REQ;
    assign capture       = dm_data_ok_i &
                           (((state_q == REQ) & dm_addr_ok_i) | (state_q == WAIT));

    if (ADDR_W <= DATA_W) begin : g_addr_trunc
        assign addr = result_q[ADDR_W-1:0];
    end else begin : g_addr_ext
        assign addr = {{(ADDR_W - DATA_W){1'b0}}, result_q};
    end

    // DONE->latch keeps back-to-back instructions bubble-free.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (latch) state_d = entry_state;
            REQ:  if (dm_addr_ok_i) state_d = dm_data_ok_i ? DONE : WAIT;
            WAIT: if (dm_data_ok_i) state_d = DONE;
            DONE: if (wb_allowin_i) state_d = latch ? entry_state : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= IDLE;
            ld_q      <= 1'b0;
            st_q      <= 1'b0;
            sign_q    <= 1'b0;
            we_q      <= 1'b0;
            ale_q     <= 1'b0;
            size_q    <= '0;
            result_q  <= '0;
            st_data_q <= '0;
            rdata_q   <= '0;
            wdest_q   <= '0;
            pc_q      <= '0;
        end else begin
            state_q <= state_d;
            if (latch) begin
                ld_q      <= ex_ld_i;
                st_q      <= ex_st_i;
                sign_q    <= ex_ld_sign_i;
                we_q      <= ex_we_i;
                ale_q     <= ex_ale;
                size_q    <= ex_size_i;
                result_q  <= ex_result_i;
                st_data_q <= ex_st_data_i;
                wdest_q   <= ex_wdest_i;
                pc_q      <= ex_pc_i;
            end
            if (capture) begin
                rdata_q <= dm_rdata_i;
            end
        end
    end

    mem_lane_align #(
        .DATA_W (DATA_W)
    ) u_align (
        .off_i     (result_q[OFF_W-1:0]),
        .size_i    (size_q),
        .st_i      (st_q),
        .ld_sign_i (sign_q),
        .st_data_i (st_data_q),
        .rdata_i   (rdata_q),
        .wbe_n_o   (dm_wbe_n_o),
        .wdata_o   (dm_wdata_o),
        .ld_data_o (ld_data)
    );

    assign we_eff            = we_q & ~ale_q;
    assign mem_result        = ld_q ? ld_data : result_q;
    assign dm_req_o          = (state_q == REQ);
    assign dm_wr_o           = (state_q == REQ) & st_q;
    assign dm_addr_o         = addr;
    assign mem_to_wb_valid_o = (state_q == DONE);
    assign ctl_mem_over_o    = (state_q == DONE);
    assign excp_ale_o        = (state_q == DONE) & ale_q;
    assign ctl_mem_dest_o    = ((state_q != IDLE) && we_eff) ? wdest_q : '0;
    assign mem2wb_bus_o      = {wdest_q, we_eff, mem_result, addr, pc_q};

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: 32- and 64-bit instances share stimulus,
// a vector table covers single transactions, hand sequences cover timing cases.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ex_valid, ex_ld, ex_st, ex_sign, ex_we;
    logic [3:0]  ex_size;
    logic [63:0] ex_result, st_data, rdata;
    logic [4:0]  ex_wdest;
    logic [31:0] ex_pc;
    logic        addr_ok, data_ok, wb_allowin;

    logic        a_allowin, a_req, a_wr, a_valid, a_over, a_ale;
    logic [31:0] a_addr, a_wdata;
    logic [3:0]  a_wbe_n;
    logic [101:0] a_bus;
    logic [4:0]  a_dest;

    logic        b_allowin, b_req, b_wr, b_valid, b_over, b_ale;
    logic [31:0] b_addr;
    logic [63:0] b_wdata;
    logic [7:0]  b_wbe_n;
    logic [133:0] b_bus;
    logic [4:0]  b_dest;

    always #5 clk = ~clk;

    mem_access_unit #(.DATA_W(32), .ADDR_W(32), .PC_W(32)) u32 (
        .clk(clk), .resetn(resetn), .ex_valid_i(ex_valid), .mem_allowin_o(a_allowin),
        .ex_ld_i(ex_ld), .ex_st_i(ex_st), .ex_ld_sign_i(ex_sign), .ex_size_i(ex_size),
        .ex_result_i(ex_result[31:0]), .ex_st_data_i(st_data[31:0]), .ex_wdest_i(ex_wdest),
        .ex_we_i(ex_we), .ex_pc_i(ex_pc), .dm_req_o(a_req), .dm_wr_o(a_wr),
        .dm_addr_o(a_addr), .dm_wbe_n_o(a_wbe_n), .dm_wdata_o(a_wdata),
        .dm_addr_ok_i(addr_ok), .dm_data_ok_i(data_ok), .dm_rdata_i(rdata[31:0]),
        .wb_allowin_i(wb_allowin), .mem_to_wb_valid_o(a_valid), .mem2wb_bus_o(a_bus),
        .ctl_mem_dest_o(a_dest), .ctl_mem_over_o(a_over), .excp_ale_o(a_ale)
    );

    mem_access_unit #(.DATA_W(64), .ADDR_W(32), .PC_W(32)) u64 (
        .clk(clk), .resetn(resetn), .ex_valid_i(ex_valid), .mem_allowin_o(b_allowin),
        .ex_ld_i(ex_ld), .ex_st_i(ex_st), .ex_ld_sign_i(ex_sign), .ex_size_i(ex_size),
        .ex_result_i(ex_result), .ex_st_data_i(st_data), .ex_wdest_i(ex_wdest),
        .ex_we_i(ex_we), .ex_pc_i(ex_pc), .dm_req_o(b_req), .dm_wr_o(b_wr),
        .dm_addr_o(b_addr), .dm_wbe_n_o(b_wbe_n), .dm_wdata_o(b_wdata),
        .dm_addr_ok_i(addr_ok), .dm_data_ok_i(data_ok), .dm_rdata_i(rdata),
        .wb_allowin_i(wb_allowin), .mem_to_wb_valid_o(b_valid), .mem2wb_bus_o(b_bus),
        .ctl_mem_dest_o(b_dest), .ctl_mem_over_o(b_over), .excp_ale_o(b_ale)
    );

    // Output view of whichever instance the current check targets.
    logic        is64;
    logic        s_allowin, s_req, s_wr, s_valid, s_over, s_ale, s_bwe;
    logic [31:0] s_addr, s_baddr, s_bpc;
    logic [63:0] s_wdata, s_res;
    logic [7:0]  s_wbe_n;
    logic [4:0]  s_dest, s_bdest;

    assign s_allowin = is64 ? b_allowin : a_allowin;
    assign s_req     = is64 ? b_req     : a_req;
    assign s_wr      = is64 ? b_wr      : a_wr;
    assign s_valid   = is64 ? b_valid   : a_valid;
    assign s_over    = is64 ? b_over    : a_over;
    assign s_ale     = is64 ? b_ale     : a_ale;
    assign s_addr    = is64 ? b_addr    : a_addr;
    assign s_wdata   = is64 ? b_wdata   : {32'd0, a_wdata};
    assign s_wbe_n   = is64 ? b_wbe_n   : {4'd0, a_wbe_n};
    assign s_dest    = is64 ? b_dest    : a_dest;
    assign s_bdest   = is64 ? b_bus[133:129] : a_bus[101:97];
    assign s_bwe     = is64 ? b_bus[128]     : a_bus[96];
    assign s_res     = is64 ? b_bus[127:64]  : {32'd0, a_bus[95:64]};
    assign s_baddr   = is64 ? b_bus[63:32]   : a_bus[63:32];
    assign s_bpc     = is64 ? b_bus[31:0]    : a_bus[31:0];

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [135:0] act, input logic [135:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ex_valid = 1'b0; ex_ld = 1'b0; ex_st = 1'b0; ex_sign = 1'b0; ex_we = 1'b0;
        ex_size = 4'b0000; ex_result = '0; st_data = '0; ex_wdest = '0; ex_pc = '0;
        addr_ok = 1'b0; data_ok = 1'b0; rdata = '0;
    endtask

    task automatic drive(input logic ld, input logic st, input logic sgn, input logic [3:0] sz,
                         input logic [63:0] addr, input logic [63:0] sd, input logic [4:0] wd,
                         input logic we, input logic [31:0] pc);
        ex_valid = 1'b1; ex_ld = ld; ex_st = st; ex_sign = sgn; ex_size = sz;
        ex_result = addr; st_data = sd; ex_wdest = wd; ex_we = we; ex_pc = pc;
    endtask

    typedef struct {
        logic        is64;
        logic        ld, st, sign;
        logic [3:0]  size;
        logic [63:0] addr, sdata, rdata;
        logic        we;
        logic [7:0]  wbe_n;
        logic [63:0] wdata, result;
        logic        ale, chkres;
    } vec_t;

    localparam logic [3:0] B = 4'b0001, H = 4'b0010, W = 4'b0100, D = 4'b1000;
    localparam int NV = 25;
    vec_t tv [NV];

    function automatic string nm(input int i, input string s);
        return $sformatf("v%0d_%s", i, s);
    endfunction

    task automatic apply_vec(input vec_t v, input int i);
        logic        mem_req;
        logic [4:0]  wd;
        logic [31:0] pc;
        mem_req = (v.ld | v.st) & ~v.ale;
        wd = 5'(i + 1);
        pc = 32'h400 + 32'(i * 4);
        drive(v.ld, v.st, v.sign, v.size, v.addr, v.sdata, wd, v.we, pc);
        @(negedge clk);
        chk(nm(i, "allowin"), s_allowin, 1);
        tick();
        ex_valid = 1'b0;
        if (mem_req) begin
            addr_ok = 1'b1; data_ok = 1'b1; rdata = v.rdata;
            @(negedge clk);
            chk(nm(i, "req"), s_req, 1);
            chk(nm(i, "wr"), s_wr, v.st);
            chk(nm(i, "addr"), s_addr, v.addr[31:0]);
            chk(nm(i, "wbe_n"), s_wbe_n, v.wbe_n);
            chk(nm(i, "wdata"), s_wdata, v.wdata);
            chk(nm(i, "over_req"), s_over, 0);
            tick();
            addr_ok = 1'b0; data_ok = 1'b0; rdata = 64'hA5A5_5A5A_A5A5_5A5A;
        end
        @(negedge clk);
        chk(nm(i, "valid"), s_valid, 1);
        chk(nm(i, "over"), s_over, 1);
        chk(nm(i, "req_done"), s_req, 0);
        chk(nm(i, "ale"), s_ale, v.ale);
        chk(nm(i, "bus_we"), s_bwe, v.we & ~v.ale);
        chk(nm(i, "bus_wdest"), s_bdest, wd);
        chk(nm(i, "bus_addr"), s_baddr, v.addr[31:0]);
        chk(nm(i, "bus_pc"), s_bpc, pc);
        if (v.chkres) chk(nm(i, "result"), s_res, v.result);
        if (!v.ale) chk(nm(i, "dest"), s_dest, v.we ? wd : 5'd0);
        if (!(v.ld | v.st)) chk(nm(i, "wbe_n_nonmem"), s_wbe_n, v.wbe_n);
        tick();
        @(negedge clk);
        chk(nm(i, "idle"), s_valid, 0);
        tick();
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    initial begin
        int over_low;
        //          is64 ld st sg sz addr           sdata                  rdata                  we wbe_n  wdata                  result                 ale chk
        tv[0]  = '{0, 1, 0, 1, B, 64'h1003, 64'h0, 64'h80FF1234, 1, 8'h0F, 64'h0, 64'hFFFFFF80, 0, 1};
        tv[1]  = '{0, 1, 0, 0, B, 64'h1003, 64'h0, 64'h80FF1234, 1, 8'h0F, 64'h0, 64'h00000080, 0, 1};
        tv[2]  = '{0, 1, 0, 1, H, 64'h1002, 64'h0, 64'h80FF1234, 1, 8'h0F, 64'h0, 64'hFFFF80FF, 0, 1};
        tv[3]  = '{0, 1, 0, 0, H, 64'h1000, 64'h0, 64'h80FF1234, 1, 8'h0F, 64'h0, 64'h00001234, 0, 1};
        tv[4]  = '{0, 1, 0, 1, W, 64'h1004, 64'h0, 64'hDEADBEEF, 1, 8'h0F, 64'h0, 64'hDEADBEEF, 0, 1};
        tv[5]  = '{0, 1, 0, 1, B, 64'h1001, 64'h0, 64'h80FF1234, 1, 8'h0F, 64'h0, 64'h00000012, 0, 1};
        tv[6]  = '{0, 1, 0, 0, H, 64'h1002, 64'h0, 64'h80FF1234, 1, 8'h0F, 64'h0, 64'h000080FF, 0, 1};
        tv[7]  = '{0, 0, 1, 0, B, 64'h2001, 64'hAB, 64'h0, 0, 8'h0D, 64'h0000AB00, 64'h2001, 0, 1};
        tv[8]  = '{0, 0, 1, 0, H, 64'h2002, 64'hBEEF, 64'h0, 0, 8'h03, 64'hBEEF0000, 64'h2002, 0, 1};
        tv[9]  = '{0, 0, 1, 0, W, 64'h2000, 64'h12345678, 64'h0, 0, 8'h00, 64'h12345678, 64'h2000, 0, 1};
        tv[10] = '{0, 0, 1, 0, B, 64'h2003, 64'hCD, 64'h0, 0, 8'h07, 64'hCD000000, 64'h2003, 0, 1};
        tv[11] = '{0, 0, 0, 0, 4'b0000, 64'h1234, 64'h0, 64'h0, 1, 8'h0F, 64'h0, 64'h1234, 0, 1};
        tv[12] = '{0, 1, 0, 0, W, 64'h3001, 64'h0, 64'h0, 1, 8'h0F, 64'h0, 64'h0, 1, 0};
        tv[13] = '{0, 0, 1, 0, H, 64'h2001, 64'h0, 64'h0, 0, 8'h0F, 64'h0, 64'h0, 1, 0};
        tv[14] = '{0, 1, 0, 1, H, 64'h1003, 64'h0, 64'h0, 1, 8'h0F, 64'h0, 64'h0, 1, 0};
        tv[15] = '{0, 1, 0, 0, W, 64'h3002, 64'h0, 64'h0, 1, 8'h0F, 64'h0, 64'h0, 1, 0};
        tv[16] = '{1, 1, 0, 0, H, 64'h1006, 64'h0, 64'h8001222233334444, 1, 8'hFF, 64'h0, 64'h8001, 0, 1};
        tv[17] = '{1, 1, 0, 1, W, 64'h1004, 64'h0, 64'h8000000155556666, 1, 8'hFF, 64'h0, 64'hFFFFFFFF80000001, 0, 1};
        tv[18] = '{1, 1, 0, 1, B, 64'h1007, 64'h0, 64'h7F00000000000000, 1, 8'hFF, 64'h0, 64'h7F, 0, 1};
        tv[19] = '{1, 1, 0, 1, D, 64'h1008, 64'h0, 64'h0123456789ABCDEF, 1, 8'hFF, 64'h0, 64'h0123456789ABCDEF, 0, 1};
        tv[20] = '{1, 0, 1, 0, B, 64'h1005, 64'hAB, 64'h0, 0, 8'hDF, 64'h0000AB0000000000, 64'h1005, 0, 1};
        tv[21] = '{1, 0, 1, 0, W, 64'h1004, 64'hDEADBEEF, 64'h0, 0, 8'h0F, 64'hDEADBEEF00000000, 64'h1004, 0, 1};
        tv[22] = '{1, 0, 1, 0, D, 64'h1000, 64'h1122334455667788, 64'h0, 0, 8'h00, 64'h1122334455667788, 64'h1000, 0, 1};
        tv[23] = '{1, 1, 0, 0, D, 64'h1004, 64'h0, 64'h0, 1, 8'hFF, 64'h0, 64'h0, 1, 0};
        tv[24] = '{1, 0, 1, 0, H, 64'h1003, 64'h0, 64'h0, 0, 8'hFF, 64'h0, 64'h0, 1, 0};

        is64 = 1'b0;
        idle_inputs();
        wb_allowin = 1'b0;
        resetn = 1'b0;
        tick();
        tick();
        @(negedge clk);
        chk("rst_valid", a_valid, 0);
        chk("rst_req", a_req, 0);
        chk("rst_wr", a_wr, 0);
        chk("rst_wbe_n", a_wbe_n, 4'hF);
        chk("rst_addr", a_addr, 0);
        chk("rst_wdata", a_wdata, 0);
        chk("rst_bus", a_bus, 0);
        chk("rst_dest", a_dest, 0);
        chk("rst_over", a_over, 0);
        chk("rst_ale", a_ale, 0);
        resetn = 1'b1;
        tick();

        wb_allowin = 1'b1;
        for (int i = 0; i < NV; i++) begin
            is64 = tv[i].is64;
            apply_vec(tv[i], i);
        end

        // lb with data_ok three cycles after addr_ok
        is64 = 1'b0;
        over_low = 0;
        drive(1, 0, 1, B, 64'h1003, 64'h0, 5'd10, 1, 32'h500);
        tick();
        ex_valid = 1'b0; addr_ok = 1'b1; rdata = 64'h11111111;
        @(negedge clk);
        chk("lbw_req", a_req, 1);
        chk("lbw_wbe_n", a_wbe_n, 4'hF);
        if (!a_over) over_low++;
        tick();
        addr_ok = 1'b0;
        @(negedge clk);
        chk("lbw_req_wait", a_req, 0);
        if (!a_over) over_low++;
        tick();
        @(negedge clk);
        if (!a_over) over_low++;
        chk("lbw_dest_wait", a_dest, 10);
        tick();
        data_ok = 1'b1; rdata = 64'h80FF1234;
        @(negedge clk);
        if (!a_over) over_low++;
        chk("lbw_valid_early", a_valid, 0);
        tick();
        data_ok = 1'b0; rdata = 64'h7F7F7F7F;
        @(negedge clk);
        chk("lbw_over_low_cycles", over_low, 4);
        chk("lbw_valid", a_valid, 1);
        chk("lbw_result", a_bus[95:64], 32'hFFFFFF80);
        tick();

        // add followed immediately by lw
        drive(0, 0, 0, 4'b0000, 64'h55, 64'h0, 5'd3, 1, 32'h600);
        tick();
        drive(1, 0, 0, W, 64'h1004, 64'h0, 5'd4, 1, 32'h604);
        @(negedge clk);
        chk("b2b_add_valid", a_valid, 1);
        chk("b2b_allowin", a_allowin, 1);
        chk("b2b_add_result", a_bus[95:64], 32'h55);
        chk("b2b_add_dest", a_dest, 3);
        tick();
        ex_valid = 1'b0; addr_ok = 1'b1; data_ok = 1'b1; rdata = 64'hCAFEF00D;
        @(negedge clk);
        chk("b2b_lw_req", a_req, 1);
        chk("b2b_lw_addr", a_addr, 32'h1004);
        chk("b2b_lw_dest", a_dest, 4);
        chk("b2b_lw_pc", a_bus[31:0], 32'h604);
        tick();
        addr_ok = 1'b0; data_ok = 1'b0;
        @(negedge clk);
        chk("b2b_lw_result", a_bus[95:64], 32'hCAFEF00D);
        tick();

        // WB back-pressure in DONE
        wb_allowin = 1'b0;
        drive(0, 0, 0, 4'b0000, 64'h77, 64'h0, 5'd7, 1, 32'h888);
        tick();
        drive(0, 0, 0, 4'b0000, 64'h99, 64'h0, 5'd9, 1, 32'h999);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("stall%0d_allowin", c), a_allowin, 0);
            chk($sformatf("stall%0d_bus", c), a_bus, {5'd7, 1'b1, 32'h77, 32'h77, 32'h888});
            tick();
        end
        ex_valid = 1'b0; wb_allowin = 1'b1;
        @(negedge clk);
        chk("stall_release_valid", a_valid, 1);
        tick();
        @(negedge clk);
        chk("stall_idle_valid", a_valid, 0);
        chk("stall_idle_bus", a_bus, {5'd7, 1'b1, 32'h77, 32'h77, 32'h888});
        chk("stall_idle_dest", a_dest, 0);
        tick();

        // 64-bit: reset while waiting for data_ok
        is64 = 1'b1;
        drive(1, 0, 0, W, 64'h1000, 64'h0, 5'd12, 1, 32'h700);
        tick();
        ex_valid = 1'b0; addr_ok = 1'b1;
        tick();
        addr_ok = 1'b0;
        @(negedge clk);
        chk("rw_wait_req", b_req, 0);
        chk("rw_wait_over", b_over, 0);
        resetn = 1'b0;
        tick();
        @(negedge clk);
        chk("rw_rst_valid", b_valid, 0);
        chk("rw_rst_req", b_req, 0);
        chk("rw_rst_wbe_n", b_wbe_n, 8'hFF);
        chk("rw_rst_bus", b_bus, 0);
        chk("rw_rst_dest", b_dest, 0);
        chk("rw_rst_over", b_over, 0);
        chk("rw_rst_addr", b_addr, 0);
        resetn = 1'b1; data_ok = 1'b1; rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        data_ok = 1'b0;
        @(negedge clk);
        chk("rw_late_dataok_valid", b_valid, 0);
        chk("rw_late_dataok_req", b_req, 0);
        chk("rw_late_dataok_allowin", b_allowin, 1);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
